mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Shares the single memory port between the instruction-fetch requester (I) and the data requester (D:
// memread/memwrite from control). Sequences each access to completion with an FSM, applies data-first priority
// with a starvation guard for fetch, and returns per-port ack/rdata plus pipeline stall flags.
// PARAMETERS
// ADDR_W        32  address width, both requesters and memory side
// DATA_W        32  read/write data width
// STARVE_LIMIT  4   consecutive D grants allowed while I waits; next grant forced to I (range 1..15)
// TIMEOUT       64  watchdog cycles per transaction (used only with MEM_ARB_TIMEOUT_EN)
// PORTS
// clk        in   1       clock, all state on rising edge
// reset_n    in   1       asynchronous, active-low reset
// i_req      in   1       fetch request; held with i_addr until i_ack
// i_addr     in   ADDR_W  fetch address
// i_ack      out  1       one-cycle pulse: fetch done, i_rdata valid this cycle
// i_rdata    out  DATA_W  fetched word, held until next I completion
// d_req      in   1       data request (memread|memwrite); held with d_we/d_addr/d_wdata until d_ack
// d_we       in   1       1 = store, 0 = load
// d_addr     in   ADDR_W  data address
// d_wdata    in   DATA_W  store data
// d_ack      out  1       one-cycle pulse: data access done, d_rdata valid for loads
// d_rdata    out  DATA_W  load data, held until next D load completion
// i_stall    out  1       i_req & ~i_ack (combinational)
// d_stall    out  1       d_req & ~d_ack (combinational)
// mem_req    out  1       memory access in progress; held until mem_ready
// mem_we     out  1       write strobe qualified by mem_req
// mem_addr   out  ADDR_W  memory address
// mem_wdata  out  DATA_W  memory write data
// mem_rdata  in   DATA_W  memory read data, valid with mem_ready
// mem_ready  in   1       one-cycle completion from memory; ignored when mem_req=0
// err        out  1       one-cycle pulse: transaction aborted by watchdog (0 when macro absent)
// BEHAVIOUR
// - Reset: state IDLE; mem_req, mem_we, i_ack, d_ack, err = 0; mem_addr, mem_wdata, i_rdata, d_rdata = 0; streak = 0.
// - Reset mid-transaction: immediate abort; no ack issued; requester must re-present after release.
// - FSM IDLE -> BUSY_I or BUSY_D on grant; BUSY_x -> IDLE on mem_ready (or timeout).
// - Arbitration in IDLE: eligible req = req & ~ack of that port this cycle (blocks duplicate on ack cycle).
//   Both eligible: D wins unless streak == STARVE_LIMIT, then I wins. Only one eligible: it wins.
// - streak: +1 on each D grant while I eligible; cleared on any I grant or when I not requesting at D grant. Saturates.
// - Grant edge registers mem_req=1, mem_we (D store only, else 0), mem_addr, mem_wdata; all held stable while busy.
// - mem_ready in cycle M: on edge M, mem_req/mem_we <= 0, rdata captured into i_rdata or d_rdata (loads only),
//   ack pulses in cycle M+1, state IDLE. New grant earliest at edge M+1 -> mem_req again in M+2.
// - Latency: req in IDLE cycle N, mem_ready in cycle N+1 -> ack in cycle N+2 (min 2 cycles + memory wait).
// - Stores: d_rdata unchanged. Request dropped while busy: transaction still completes; ack ignored by requester.
// - i_ack and d_ack never asserted in the same cycle; err and ack never in the same cycle.
// CONFIGURATION
// MEM_ARB_TIMEOUT_EN defined: counter cleared at grant, +1 each busy cycle without mem_ready; reaching TIMEOUT
//   forces IDLE, mem_req=0, err pulse next cycle, no ack, rdata regs unchanged; the requester keeps stalling
//   and is re-arbitrated normally. Not defined: no counter, err tied 0, BUSY waits indefinitely.
// TESTING
// - Lone fetch: i_req=1 addr 0x100, mem_ready 2 cycles after mem_req, rdata 0xDEADBEEF -> i_ack 1 cycle, i_rdata=0xDEADBEEF, mem_we=0.
// - Simultaneous i_req/d_req (store 0x55 @0x40) -> D granted first, mem_we=1 mem_wdata=0x55; I granted right after D ack.
// - Starvation: d_req held high continuously, i_req high, STARVE_LIMIT=4 -> 4 D grants then I grant, streak cleared.
// - Held req across ack: d_req stays high 1 cycle past d_ack -> no second mem_req for D in that cycle.
// - Reset asserted mid-BUSY_D -> mem_req=0 immediately, no d_ack, state IDLE after release; redo completes normally.
// - With MEM_ARB_TIMEOUT_EN, TIMEOUT=8, mem_ready never -> err pulse after 8 busy cycles, mem_req=0, no i_ack/d_ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by fetch (I) and data (D) requesters, data-first with a fetch starvation guard.
// Optional per-transaction watchdog abort is built when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              i_stall,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    localparam int unsigned STREAK_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                i_ack_q, i_ack_d;
    logic                d_ack_q, d_ack_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    logic elig_fetch, elig_data;
    logic grant_fetch, grant_data;
    logic busy, done, timeout;

    // A port is not eligible in its own ack cycle, so a held request cannot re-issue.
    assign elig_fetch = i_req & ~i_ack_q;
    assign elig_data  = d_req & ~d_ack_q;
    assign busy       = (state_q != IDLE);
    assign done       = busy & mem_ready;

    always_comb begin
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        if (state_q == IDLE) begin
            if (elig_data && !(elig_fetch && (streak_q == STREAK_W'(STARVE_LIMIT)))) begin
                grant_data = 1'b1;
            end else if (elig_fetch) begin
                grant_fetch = 1'b1;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;

    // Abort on the TIMEOUT-th busy cycle that sees no mem_ready.
    assign timeout = busy & ~mem_ready & (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (grant_fetch || grant_data) begin
            cnt_d = '0;
        end else if (busy && !mem_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= timeout;
        end
    end

    assign err = err_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign timeout        = 1'b0;
    assign err            = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d = BUSY_D;
                end else if (grant_fetch) begin
                    state_d = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (done || timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered memory-side, ack and read-data outputs.
    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        streak_d    = streak_q;

        if (grant_data) begin
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            if (!elig_fetch) begin
                streak_d = '0;
            end else if (streak_q != '1) begin
                streak_d = streak_q + STREAK_W'(1);
            end
        end else if (grant_fetch) begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = i_addr;
            streak_d   = '0;
        end

        if (done) begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            if (state_q == BUSY_I) begin
                i_ack_d   = 1'b1;
                i_rdata_d = mem_rdata;
            end else begin
                d_ack_d = 1'b1;
                if (!mem_we_q) begin
                    d_rdata_d = mem_rdata;
                end
            end
        end else if (timeout) begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            streak_q    <= '0;
        end else begin
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            streak_q    <= streak_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_stall   = i_req & ~i_ack_q;
    assign d_stall   = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level model of the arbitration rules and a behavioural memory responder.
module tb_mem_port_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;
    localparam int TMO   = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_req, d_req, d_we, mem_ready;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic          i_ack, d_ack, i_stall, d_stall, mem_req, mem_we, err;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .i_stall(i_stall), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Transaction-level model state.
    bit          m_busy, m_is_d, m_we;
    logic [31:0] m_addr, m_wdata, e_irdata, e_drdata;
    bit          e_iack, e_dack, e_err;
    int          m_streak, m_cnt;
    bit          grants[$];

    // Memory responder state.
    bit          r_active, never_ready, rd_force;
    int          r_wait, fixed_wait;
    logic [31:0] rd_val;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_busy = 0; m_is_d = 0; m_we = 0; m_addr = '0; m_wdata = '0;
        e_irdata = '0; e_drdata = '0; e_iack = 0; e_dack = 0; e_err = 0;
        m_streak = 0; m_cnt = 0; r_active = 0;
    endtask

    // One clock: respond as memory, advance the model on this cycle's inputs, check next cycle.
    task automatic tick();
        bit ei, ed, pick_d;
        if (mem_req) begin
            if (!r_active) begin
                r_active = 1;
                r_wait = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
            end
            if (!never_ready && r_wait == 0) begin
                mem_ready = 1'b1;
                mem_rdata = rd_force ? rd_val : mem_data(mem_addr);
                r_active  = 0;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                if (r_wait > 0) r_wait--;
            end
        end else begin
            r_active  = 0;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
        end
        #1;
        chk("i_stall", i_stall, i_req & ~e_iack);
        chk("d_stall", d_stall, d_req & ~e_dack);

        ei = i_req & ~e_iack;
        ed = d_req & ~e_dack;
        e_iack = 0; e_dack = 0; e_err = 0;
        if (m_busy) begin
            if (mem_ready) begin
                m_busy = 0;
                if (m_is_d) begin
                    e_dack = 1;
                    if (!m_we) e_drdata = mem_rdata;
                end else begin
                    e_iack   = 1;
                    e_irdata = mem_rdata;
                end
            end else begin
                m_cnt++;
`ifdef MEM_ARB_TIMEOUT_EN
                if (m_cnt == TMO) begin
                    m_busy = 0;
                    e_err  = 1;
                end
`endif
            end
        end else if (ei || ed) begin
            pick_d = ed && !(ei && m_streak == LIMIT);
            grants.push_back(pick_d);
            m_busy = 1; m_is_d = pick_d; m_cnt = 0;
            if (pick_d) begin
                m_addr = d_addr; m_we = d_we;
                if (d_we) m_wdata = d_wdata;
                m_streak = ei ? m_streak + 1 : 0;
            end else begin
                m_addr = i_addr; m_we = 0; m_streak = 0;
            end
        end

        @(posedge clk); #1;
        chk("mem_req", mem_req, m_busy);
        chk("mem_we", mem_we, m_busy & m_we);
        chk("mem_addr", mem_addr, m_addr);
        if (m_busy && m_we) chk("mem_wdata", mem_wdata, m_wdata);
        chk("i_ack", i_ack, e_iack);
        chk("d_ack", d_ack, e_dack);
        chk("err", err, e_err);
        chk("i_rdata", i_rdata, e_irdata);
        chk("d_rdata", d_rdata, e_drdata);
    endtask

    // Run until the wanted acks arrive (requests dropped in the ack cycle), bounded by max ticks.
    task automatic serve(input bit want_i, input bit want_d, input int max,
                         output int t_i, output int t_d);
        t_i = -1; t_d = -1;
        for (int k = 1; k <= max; k++) begin
            tick();
            if (i_ack && i_req) begin t_i = k; i_req = 0; end
            if (d_ack && d_req) begin t_d = k; d_req = 0; end
            if ((!want_i || t_i > 0) && (!want_d || t_d > 0)) break;
        end
        chk("serve_done", {(t_i > 0) || !want_i, (t_d > 0) || !want_d}, 2'b11);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; i_req = 0; d_req = 0; mem_ready = 0;
        #1;
        chk("rst_async_mem_req", mem_req, 0);
        chk("rst_async_d_ack", d_ack, 0);
        model_clear();
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_hold_ack", {i_ack, d_ack, err}, 3'b000);
        end
        reset_n = 1'b1;
    endtask

    initial begin
        int ti, td, run, max_run, n_ig, t_err;
        reset_n = 1'b0; i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0;
        d_wdata = '0; mem_rdata = '0; mem_ready = 0;
        never_ready = 0; rd_force = 0; rd_val = '0; fixed_wait = -1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {mem_req, mem_we, i_ack, d_ack, err}, 5'b0);
        chk("reset_addr", mem_addr, 0);
        chk("reset_wdata", mem_wdata, 0);
        chk("reset_rdata", {i_rdata, d_rdata}, 0);
        reset_n = 1'b1;

        // Lone fetch, memory answers two cycles after mem_req.
        i_req = 1; i_addr = 32'h100; fixed_wait = 2; rd_force = 1; rd_val = 32'hDEAD_BEEF;
        serve(1, 0, 12, ti, td);
        chk("fetch_latency", ti, 4);
        chk("fetch_rdata", i_rdata, 32'hDEAD_BEEF);
        rd_force = 0;
        tick();

        // Simultaneous requests: store wins, fetch follows right after the store ack.
        fixed_wait = 0;
        i_req = 1; i_addr = 32'h200;
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h55;
        tick();
        chk("simul_d_first_we", mem_we, 1);
        chk("simul_d_wdata", mem_wdata, 32'h55);
        chk("simul_d_addr", mem_addr, 32'h40);
        serve(1, 1, 12, ti, td);
        chk("simul_d_ack_t", td, 1);
        chk("simul_i_ack_t", ti, 3);
        chk("simul_store_keeps_drdata", d_rdata, 0);
        tick();

        // Load at minimum latency, request held one cycle past its ack.
        d_req = 1; d_we = 0; d_addr = 32'h80;
        tick();
        tick();
        chk("load_min_latency_ack", d_ack, 1);
        chk("load_rdata", d_rdata, mem_data(32'h80));
        tick();
        chk("held_no_reissue", mem_req, 0);
        d_req = 0;
        tick();

        // Both requesters held high continuously: fetch is never passed over more than LIMIT times.
        grants.delete();
        fixed_wait = -1;
        i_req = 1; i_addr = 32'h1000;
        d_req = 1; d_we = 0; d_addr = 32'h2000;
        repeat (40) tick();
        i_req = 0; d_req = 0;
        repeat (6) tick();
        run = 0; max_run = 0; n_ig = 0;
        foreach (grants[k]) begin
            if (grants[k]) begin
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0; n_ig++;
            end
        end
        chk("starve_max_d_run", max_run <= LIMIT, 1);
        chk("starve_i_served", n_ig > 0, 1);

        // Reset in the middle of a store, then redo it.
        fixed_wait = 5;
        d_req = 1; d_we = 1; d_addr = 32'h44; d_wdata = 32'hA5;
        tick();
        tick();
        chk("rst_pre_busy", mem_req, 1);
        apply_reset();
        fixed_wait = 1;
        d_req = 1; d_we = 1; d_addr = 32'h44; d_wdata = 32'hA5;
        serve(0, 1, 12, ti, td);
        chk("rst_redo_ack_t", td, 3);
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never answers: abort with err, then fetch is re-arbitrated.
        never_ready = 1;
        i_req = 1; i_addr = 32'h300;
        t_err = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (err) begin t_err = k; break; end
        end
        chk("tmo_err_cycle", t_err, 9);
        chk("tmo_mem_req", mem_req, 0);
        chk("tmo_no_ack", {i_ack, d_ack}, 2'b00);
        never_ready = 0; fixed_wait = 0;
        serve(1, 0, 12, ti, td);
        chk("tmo_regrant_ack_t", ti, 2);
        tick();
`else
        t_err = 0;
`endif

        // Random traffic against the model.
        fixed_wait = -1;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (i_ack) begin
                i_req = 1'($urandom_range(0, 1));
            end else if (!i_req && $urandom_range(0, 9) < 4) begin
                i_req = 1; i_addr = 32'($urandom_range(0, 1023)) << 2;
            end
            if (d_ack) begin
                d_req = 1'($urandom_range(0, 1));
            end else if (!d_req && $urandom_range(0, 9) < 5) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1));
                d_addr = 32'($urandom_range(0, 1023)) << 2; d_wdata = $urandom;
            end
        end
        i_req = 0; d_req = 0;
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
